// File: rtl/std_csr_pkg.sv
// Shared definitions for the CSR bit-write front end.
//   csr_op_e          : request operation encodings (matches the 2-bit req_op port)
//   csr_bitwr_state_e : control FSM states of std_csr_bitwr
package std_csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    CSR_BITWR_IDLE = 2'b00,
    CSR_BITWR_EXEC = 2'b01,
    CSR_BITWR_RESP = 2'b10
  } csr_bitwr_state_e;

endpackage

// File: rtl/std_csr_bitwr_mask.sv
// Combinational enable/data generator for a bit-enable storage element.
// Ports:
//   op        : requested operation (read/write/set/clear)
//   data      : write value, or set/clear bit mask
//   stor_q    : current storage value (used for read-only violation detection)
//   en        : per-bit enable, never set outside WMASK
//   d         : per-bit data
//   violation : request touches a read-only bit
module std_csr_bitwr_mask
  import std_csr_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] WMASK      = '1
) (
  input  csr_op_e               op,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] stor_q,
  output logic [DATA_WIDTH-1:0] en,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  violation
);

  always_comb begin
    en        = '0;
    d         = '0;
    violation = 1'b0;
    case (op)
      CSR_OP_WRITE: begin
        en        = WMASK;
        d         = data;
        // A write that merely restates the read-only bits is not a violation.
        violation = |((data ^ stor_q) & ~WMASK);
      end
      CSR_OP_SET: begin
        en        = data & WMASK;
        d         = '1;
        violation = |(data & ~WMASK);
      end
      CSR_OP_CLEAR: begin
        en        = data & WMASK;
        d         = '0;
        violation = |(data & ~WMASK);
      end
      default: begin
        en        = '0;
        d         = '0;
        violation = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/std_csr_bitwr.sv
// Read-modify-write control stage in front of a bit-enable DFF storage.
// Accepts one read/write/set/clear request, drives the storage enable/data for
// exactly one cycle, then returns the pre-update storage value.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake; req_op, req_data carry the request
//   stor_q               : storage current value
//   stor_en, stor_d      : storage per-bit enable and data (non-zero only in EXEC)
//   rsp_valid/rsp_ready  : response handshake; rsp_rdata, rsp_err carry the response
// Optional feature: define STD_CSR_BITWR_ROERR_EN to suppress requests touching
// read-only bits and flag them on rsp_err; otherwise rsp_err is constant 0.
module std_csr_bitwr
  import std_csr_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] WMASK      = '1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [DATA_WIDTH-1:0] stor_q,
  output logic [DATA_WIDTH-1:0] stor_en,
  output logic [DATA_WIDTH-1:0] stor_d,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  csr_bitwr_state_e      state_q, state_d;
  csr_op_e               op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  capture_req;
  logic                  capture_rsp;

  logic [DATA_WIDTH-1:0] mask_en;
  logic [DATA_WIDTH-1:0] mask_d;
  logic                  mask_violation;
  logic                  exec_violation;

  std_csr_bitwr_mask #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK      (WMASK)
  ) u_mask (
    .op        (op_q),
    .data      (data_q),
    .stor_q    (stor_q),
    .en        (mask_en),
    .d         (mask_d),
    .violation (mask_violation)
  );

`ifdef STD_CSR_BITWR_ROERR_EN
  assign exec_violation = mask_violation;
`else
  logic unused_violation;
  assign unused_violation = mask_violation;
  assign exec_violation   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CSR_BITWR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= CSR_OP_READ;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture_req) begin
        op_q   <= csr_op_e'(req_op);
        data_q <= req_data;
      end
      if (capture_rsp) begin
        rdata_q <= stor_q;
        err_q   <= exec_violation;
      end
    end
  end

  // Storage controls depend only on registered state and the captured request,
  // so reset forces stor_en low through state_q without a clock edge.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    stor_en     = '0;
    stor_d      = '0;
    capture_req = 1'b0;
    capture_rsp = 1'b0;
    case (state_q)
      CSR_BITWR_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture_req = 1'b1;
          state_d     = CSR_BITWR_EXEC;
        end
      end
      CSR_BITWR_EXEC: begin
        stor_en     = exec_violation ? '0 : mask_en;
        stor_d      = mask_d;
        capture_rsp = 1'b1;
        state_d     = CSR_BITWR_RESP;
      end
      CSR_BITWR_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = CSR_BITWR_IDLE;
        end
      end
      default: begin
        state_d = CSR_BITWR_IDLE;
      end
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
